serdes_10b: RTL and testbench
=============================

// Module: serdes_10b
// PURPOSE
//  Single-clock 10-bit SERDES for the link datapath.
//  TX half: repeatedly loads a parallel word and shifts it out serially, LSB first.
//  RX half: deserializes a serial stream into parallel words, with optional polarity
//  inversion (NEG) and comma-based word alignment.
//  Sits between the 10-bit encoder/decoder and the serial pin; combines par2ser,
//  ser2par and a common clock domain.
// PARAMETERS
//  WIDTH  10            word width in bits (>=4)
//  COMMA  10'b0011111010 alignment pattern, in received bit order; its complement also matches
// PORTS
//  CLK       in   1      system clock, all logic on rising edge
//  RST       in   1      synchronous, active-high reset
//  INP_PAR   in   WIDTH  TX parallel word, sampled when a new word is loaded
//  LOAD_ACK  out  1      1-cycle pulse: INP_PAR was captured on this edge
//  OUT_SER   out  1      TX serial data, registered
//  INP_SER   in   1      RX serial data, sampled every rising edge
//  NEG       in   1      1 = invert INP_SER before deserializing
//  ALIGN_EN  in   1      1 = enable comma alignment
//  OUT_PAR   out  WIDTH  RX parallel word, registered, held between updates
//  PAR_VALID out  1      1-cycle pulse: OUT_PAR updated on this edge
//  ALIGNED   out  1      sticky flag: a comma has been detected since reset
// BEHAVIOUR
//  Reset is synchronous. With RST=1 at an edge:
//   - OUT_SER, LOAD_ACK, OUT_PAR, PAR_VALID, ALIGNED = 0
//   - tx_cnt = rx_cnt = 0; both shift registers = 0
//   - reset wins over all other activity, including mid-word.
//  TX (tx_cnt runs 0..WIDTH-1, then wraps):
//   - Edge with tx_cnt==0: OUT_SER<=INP_PAR[0]; tx_sh<=INP_PAR>>1; LOAD_ACK<=1.
//   - Other edges: OUT_SER<=tx_sh[0]; tx_sh<=tx_sh>>1; LOAD_ACK<=0.
//   - The first edge after RST falls loads a word. Words go out back-to-back with no
//     idle bits. INP_PAR changes between loads have no effect.
//  RX:
//   - d = INP_SER ^ NEG.
//   - Each edge: win = {d, rx_sh[WIDTH-1:1]}; rx_sh<=win. The first-received bit
//     ends up in bit 0.
//   - Comma hit = ALIGN_EN && (win==COMMA || win==~COMMA). On a hit:
//     OUT_PAR<=win; PAR_VALID<=1; rx_cnt<=0; ALIGNED<=1.
//   - Else if rx_cnt==WIDTH-1: OUT_PAR<=win; PAR_VALID<=1; rx_cnt<=0.
//   - Else: rx_cnt<=rx_cnt+1; PAR_VALID<=0.
//   - A hit coinciding with the count wrap gives one word and one PAR_VALID pulse.
//   - With ALIGN_EN=0, framing is free-running from reset and ALIGNED holds its value.
//   - A NEG change takes effect on the next edge; already shifted bits are not modified.
//  Latency:
//   - TX: bit k of a word appears on OUT_SER k cycles after its load edge.
//   - RX: OUT_PAR valid on the edge the WIDTH-th bit is sampled.
//   - TX and RX counters are independent.
// TESTING
//  1 TX, INP_PAR=35 held: OUT_SER repeats 1,1,0,0,0,1,0,0,0,0; LOAD_ACK pulses
//    every 10 cycles, first on edge 1 after reset.
//  2 RX, INP_SER=1, NEG=0, ALIGN_EN=0: PAR_VALID every 10 cycles, OUT_PAR=10'h3FF.
//    With NEG=1: OUT_PAR=10'h000.
//  3 RX, INP_SER toggling every cycle starting at 1, NEG=0: OUT_PAR=10'h155
//    (alternating bits, first bit in bit 0). With NEG=1: 10'h2AA.
//  4 Loopback OUT_SER->INP_SER, ALIGN_EN=1, TX sends COMMA, then 35, then COMMA
//    repeatedly: ALIGNED=1 after the first comma; thereafter OUT_PAR alternates
//    COMMA and 35, one PAR_VALID per word.
//  5 RST=1 mid-word for 1 cycle: all outputs 0 on that edge. TX reloads INP_PAR on
//    the next edge; RX word boundary restarts from that edge.
//  6 Comma arrives when rx_cnt=4 with ALIGN_EN=1: OUT_PAR=COMMA, PAR_VALID=1, the
//    next word completes exactly 10 edges later.

Source files
------------

// File: rtl/serdes_10b.sv
// serdes_10b: single-clock 10-bit SERDES.
//   TX: every WIDTH cycles it loads INP_PAR and shifts it out on OUT_SER, LSB
//       first. Words are sent back-to-back.
//   RX: deserializes INP_SER into OUT_PAR. NEG optionally inverts the input.
//       With ALIGN_EN set, the word boundary is realigned on a comma.
// Ports:
//   CLK       system clock, rising edge
//   RST       synchronous active-high reset
//   INP_PAR   TX parallel word, sampled on load edges
//   LOAD_ACK  pulse: INP_PAR was captured on this edge
//   OUT_SER   TX serial data (registered)
//   INP_SER   RX serial data
//   NEG       invert INP_SER before deserializing
//   ALIGN_EN  enable comma alignment
//   OUT_PAR   RX parallel word (registered, held between updates)
//   PAR_VALID pulse: OUT_PAR updated on this edge
//   ALIGNED   sticky: a comma has been seen since reset
module serdes_10b #(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(10'b0011111010)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] INP_PAR,
  output logic             LOAD_ACK,
  output logic             OUT_SER,
  input  logic             INP_SER,
  input  logic             NEG,
  input  logic             ALIGN_EN,
  output logic [WIDTH-1:0] OUT_PAR,
  output logic             PAR_VALID,
  output logic             ALIGNED
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic             out_ser_q, out_ser_d;
  logic             load_ack_q, load_ack_d;

  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] out_par_q, out_par_d;
  logic             par_valid_q, par_valid_d;
  logic             aligned_q, aligned_d;

  logic             rx_bit;
  logic [WIDTH-1:0] win;
  logic             comma_hit;

  // TX: count 0 loads the new word and emits its bit 0 directly, so the
  // shifter only ever holds the remaining WIDTH-1 bits.
  always_comb begin
    tx_cnt_d = (tx_cnt_q == LAST) ? '0 : tx_cnt_q + CW'(1);
    if (tx_cnt_q == '0) begin
      out_ser_d  = INP_PAR[0];
      tx_sh_d    = INP_PAR >> 1;
      load_ack_d = 1'b1;
    end else begin
      out_ser_d  = tx_sh_q[0];
      tx_sh_d    = tx_sh_q >> 1;
      load_ack_d = 1'b0;
    end
  end

  // RX: new bit enters at the MSB, so after WIDTH edges the first-received
  // bit sits in bit 0. The comma is matched on the window including the
  // bit sampled this edge, so a hit and a count wrap yield one word.
  always_comb begin
    rx_bit      = INP_SER ^ NEG;
    win         = {rx_bit, rx_sh_q[WIDTH-1:1]};
    comma_hit   = ALIGN_EN && ((win == COMMA) || (win == ~COMMA));
    rx_sh_d     = win;
    out_par_d   = out_par_q;
    par_valid_d = 1'b0;
    aligned_d   = aligned_q;
    rx_cnt_d    = rx_cnt_q + CW'(1);
    if (comma_hit || (rx_cnt_q == LAST)) begin
      out_par_d   = win;
      par_valid_d = 1'b1;
      rx_cnt_d    = '0;
    end
    if (comma_hit) begin
      aligned_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_cnt_q    <= '0;
      tx_sh_q     <= '0;
      out_ser_q   <= 1'b0;
      load_ack_q  <= 1'b0;
      rx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      out_par_q   <= '0;
      par_valid_q <= 1'b0;
      aligned_q   <= 1'b0;
    end else begin
      tx_cnt_q    <= tx_cnt_d;
      tx_sh_q     <= tx_sh_d;
      out_ser_q   <= out_ser_d;
      load_ack_q  <= load_ack_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_sh_q     <= rx_sh_d;
      out_par_q   <= out_par_d;
      par_valid_q <= par_valid_d;
      aligned_q   <= aligned_d;
    end
  end

  assign OUT_SER   = out_ser_q;
  assign LOAD_ACK  = load_ack_q;
  assign OUT_PAR   = out_par_q;
  assign PAR_VALID = par_valid_q;
  assign ALIGNED   = aligned_q;

endmodule

// File: tb/tb_serdes_10b.sv
// tb_serdes_10b: scoreboard bench for serdes_10b. A stimulus process drives
// inputs on the falling edge and pushes the reference model's expectations;
// a monitor process checks the DUT just after each rising edge.
module tb_serdes_10b;

  localparam int unsigned  W     = 10;
  localparam logic [W-1:0] COMMA = 10'b0011111010;
  localparam logic [W-1:0] K35   = 10'd35;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] INP_PAR = '0;
  logic         LOAD_ACK, OUT_SER;
  logic         INP_SER = 1'b0, NEG = 1'b0, ALIGN_EN = 1'b0;
  logic [W-1:0] OUT_PAR;
  logic         PAR_VALID, ALIGNED;

  always #5 CLK = ~CLK;

  serdes_10b #(.WIDTH(W), .COMMA(COMMA)) dut (
    .CLK(CLK), .RST(RST), .INP_PAR(INP_PAR), .LOAD_ACK(LOAD_ACK),
    .OUT_SER(OUT_SER), .INP_SER(INP_SER), .NEG(NEG), .ALIGN_EN(ALIGN_EN),
    .OUT_PAR(OUT_PAR), .PAR_VALID(PAR_VALID), .ALIGNED(ALIGNED)
  );

  typedef struct packed {
    logic         ser, ack, pv, al, chk_par;
    logic [W-1:0] par;
  } exp_t;

  exp_t         cyc_q[$];
  logic [W-1:0] word_q[$];
  int           n_cmp = 0, n_bad = 0;
  bit           started = 0;

  // Reference model state: positions within the current words, not registers.
  int           m_phase;
  logic [W-1:0] m_txw;
  logic         m_ser, m_al;
  bit           m_hist[$];   // last W received bits, oldest first
  int           m_nbits;     // bits received since last word boundary

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [W-1:0] par,
                            input logic ser, input logic neg, input logic al);
    exp_t         e;
    logic [W-1:0] win;
    logic         hit;
    e = '0;
    if (rst) begin
      m_phase = 0; m_ser = 0; m_al = 0; m_nbits = 0; m_txw = '0;
      m_hist.delete();
      for (int i = 0; i < int'(W); i++) m_hist.push_back(1'b0);
      e.chk_par = 1'b1;
    end else begin
      if (m_phase == 0) m_txw = par;
      e.ack   = (m_phase == 0);
      m_ser   = m_txw[m_phase];
      e.ser   = m_ser;
      m_phase = (m_phase + 1) % int'(W);

      m_hist.push_back(ser ^ neg);
      void'(m_hist.pop_front());
      for (int i = 0; i < int'(W); i++) win[i] = m_hist[i];
      hit = al && (win == COMMA || win == ~COMMA);
      m_nbits++;
      if (hit || m_nbits == int'(W)) begin
        e.pv = 1'b1;
        word_q.push_back(win);
        m_nbits = 0;
      end
      if (hit) m_al = 1'b1;
      e.al = m_al;
    end
    cyc_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [W-1:0] par,
                      input logic ser, input logic neg, input logic al);
    @(negedge CLK);
    RST = rst; INP_PAR = par; INP_SER = ser; NEG = neg; ALIGN_EN = al;
    model_step(rst, par, ser, neg, al);
    started = 1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (started) begin
        if (cyc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cycq: no expectation queued at %0t", $time);
        end else begin
          e = cyc_q.pop_front();
          check("OUT_SER",   W'(OUT_SER),   W'(e.ser));
          check("LOAD_ACK",  W'(LOAD_ACK),  W'(e.ack));
          check("PAR_VALID", W'(PAR_VALID), W'(e.pv));
          check("ALIGNED",   W'(ALIGNED),   W'(e.al));
          if (e.chk_par) check("OUT_PAR_rst", OUT_PAR, e.par);
        end
        if (PAR_VALID === 1'b1) begin
          if (word_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL word: unexpected PAR_VALID, got %h expected none", OUT_PAR);
          end else begin
            check("OUT_PAR", OUT_PAR, word_q.pop_front());
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit           sel;
    bit           inj_q[$];
    logic         neg_r, al_r, b;
    logic [W-1:0] cm;

    // 1: TX with 35 held, RX idle
    step(1, K35, 0, 0, 0);
    step(1, K35, 0, 0, 0);
    for (int i = 0; i < 35; i++) step(0, K35, 0, 0, 0);

    // 2: RX constant 1, NEG=0 then NEG=1
    step(1, '0, 1, 0, 0);
    for (int i = 0; i < 25; i++) step(0, W'($urandom), 1, 0, 0);
    for (int i = 0; i < 25; i++) step(0, W'($urandom), 1, 1, 0);

    // 3: RX toggling from 1, NEG=0 then NEG=1 (fresh framing each)
    step(1, '0, 0, 0, 0);
    for (int i = 0; i < 30; i++) step(0, W'($urandom), logic'(i % 2 == 0), 0, 0);
    step(1, '0, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, W'($urandom), logic'(i % 2 == 0), 1, 0);

    // 4: loopback, COMMA / 35 alternating, random INP_PAR between loads
    step(1, '0, 0, 0, 1);
    sel = 1;
    for (int i = 0; i < 80; i++) begin
      if (m_phase == 0) begin
        step(0, sel ? COMMA : K35, m_ser, 0, 1);
        sel = ~sel;
      end else begin
        step(0, W'($urandom), m_ser, 0, 1);
      end
    end

    // 5: one-cycle reset in mid-word
    for (int i = 0; i < 4; i++) step(0, W'($urandom), 1'($urandom), 0, 1);
    step(1, W'($urandom), 1'($urandom), 0, 1);
    for (int i = 0; i < 25; i++) step(0, W'($urandom), 1'($urandom), 0, 0);

    // 6: comma landing on a count wrap, then a comma ending at count 4
    cm = COMMA;
    step(1, '0, 0, 0, 1);
    for (int i = 0; i < int'(W); i++) step(0, W'($urandom), cm[i], 0, 1);
    for (int i = 0; i < 12; i++) step(0, W'($urandom), 0, 0, 1);
    step(1, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, W'($urandom), 1, 0, 1);
    for (int i = 0; i < int'(W); i++) step(0, W'($urandom), cm[i], 0, 1);
    for (int i = 0; i < 22; i++) step(0, W'($urandom), 1'($urandom), 0, 1);

    // Random traffic with injected commas, NEG flips and sparse resets
    neg_r = 0; al_r = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) neg_r = ~neg_r;
      if ($urandom_range(0, 99) == 0) al_r = ~al_r;
      if (inj_q.size() == 0 && $urandom_range(0, 29) == 0) begin
        cm = $urandom_range(0, 1) ? COMMA : ~COMMA;
        for (int k = 0; k < int'(W); k++) inj_q.push_back(cm[k]);
      end
      b = (inj_q.size() != 0) ? (inj_q.pop_front() ^ neg_r) : 1'($urandom);
      step(logic'($urandom_range(0, 199) == 0), W'($urandom), b, neg_r, al_r);
    end

    @(posedge CLK);
    #2;
    check("cyc_drain",  W'(cyc_q.size()),  '0);
    check("word_drain", W'(word_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
